spi_slave_param: RTL and testbench
==================================

// Module: spi_slave_param
// PURPOSE
//  Parametrised SPI slave front end between an external SPI master and a single-port RAM.
//  Deserialises command frames on MOSI into {cmd[1:0], payload} words for the RAM.
//  For read-data commands, waits for the RAM's tx_valid handshake and serialises tx_data on MISO.
//  Adds a bounded tx wait, clean mid-frame abort, and generic data width to the 8-bit-only generation.
// PARAMETERS
//  DATA_W       8   payload / RAM data width; rx word RX_W = DATA_W+2 (localparam)
//  TX_WAIT_MAX  15  max cycles in WAIT_TX without tx_valid before abandoning the read (>=1)
// PORTS
//  clk       in   1         single clock; MOSI sampled and MISO driven on rising edge
//  rst       in   1         synchronous, active-high reset
//  SS_n      in   1         slave select, active low; frame = SS_n low period
//  MOSI      in   1         serial in, MSB first
//  MISO      out  1         serial out, MSB first; 0 when not sending
//  rx_data   out  DATA_W+2  {cmd[1:0], payload}; cmd 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//  rx_valid  out  1         1-cycle pulse: rx_data holds a complete new word
//  tx_data   in   DATA_W    read data from RAM
//  tx_valid  in   1         tx_data valid; sampled only in WAIT_TX
//  rd_pend   out  1         rd-addr frame done, rd-data frame not yet completed
// BEHAVIOUR
//  Reset: state IDLE; MISO=0, rx_valid=0, rx_data=0, rd_pend=0; counters and shift regs 0.
//  States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE.
//  IDLE: SS_n=0 at edge k -> CHK_CMD. Master presents word bit RX_W-1 (cmd[1]) for edge k+1.
//  CHK_CMD (edge k+1): samples MOSI as bit RX_W-1. 0 -> WRITE; 1 & !rd_pend -> READ_ADD; 1 & rd_pend -> READ_DATA.
//  WRITE/READ_ADD/READ_DATA: bits RX_W-2..0 sampled at edges k+2..k+RX_W.
//  Last-bit edge: rx_data <= full word, rx_valid <= 1; rx_valid clears next edge.
//  rx_data holds its value until the next completed word.
//  After the last bit: WRITE/READ_ADD -> DONE; READ_DATA -> WAIT_TX.
//  READ_ADD completion sets rd_pend.
//  Branch uses the sampled bit, not the cmd field; cmd in rx_data is passed through unchecked.
//  WAIT_TX: edge with tx_valid=1 latches tx_data -> SEND. MISO = tx_data[DATA_W-1] in the following cycle,
//   then one bit per cycle MSB first, DATA_W cycles total; then MISO=0, rd_pend cleared, -> DONE.
//  WAIT_TX timeout: TX_WAIT_MAX cycles with tx_valid=0 -> DONE; MISO stays 0; rd_pend kept so master can retry.
//  DONE: ignore MOSI, hold MISO=0 until SS_n=1 -> IDLE. Extra bits after a word are never a second word.
//  Abort: SS_n=1 sampled in any state except IDLE -> IDLE next edge.
//   No rx_valid for partial words; counters cleared; MISO <= 0 same edge; rd_pend unchanged.
//  tx_valid outside WAIT_TX is ignored, including in the rx_valid cycle.
//  Counters: bit counter $clog2(RX_W+1) bits, wait counter $clog2(TX_WAIT_MAX+1) bits; no wrap in legal use.
//  rst mid-frame: full reset values at that edge, including rd_pend=0.
// CONFIGURATION
//  SPI_SLAVE_ERR_EN defined: adds output frame_err (1 bit, reset 0).
//   1-cycle pulse on an abort before word/SEND completion, or on WAIT_TX timeout.
//  Undefined: no frame_err port; behaviour otherwise identical.
// TESTING (DATA_W=8, TX_WAIT_MAX=15)
//  SS_n low, bits 00_1010_0101 from edge 1 -> rx_data=10'h0A5, rx_valid high one cycle after edge 10; MISO=0.
//  Frame 10_0000_0011 -> rx_data=10'h203, rd_pend=1.
//   Next frame 11_xxxx_xxxx, tx_valid+tx_data=8'hC3 after 3 cycles -> MISO 1,1,0,0,0,0,1,1; rd_pend=0.
//  rd_pend=1, rd-data frame, no tx_valid -> DONE after 15 cycles; MISO=0; rd_pend stays 1; frame_err pulse if ERR_EN.
//  SS_n high after 5 write bits -> IDLE, no rx_valid, rx_data unchanged.
//   Next full frame 01_1111_0000 -> rx_data=10'h1F0.
//  rst=1 during SEND after 3 bits -> MISO=0, rd_pend=0, IDLE.
//   Next frame with cmd bit 1 goes to READ_ADD.
//  DATA_W=16: write frame 18'h0_BEEF -> rx_data=18'h0BEEF after 18 bits; tx_valid pulse during WRITE ignored.

Source files
------------

// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - SPI slave front end between an SPI master and a single-port RAM
// Optional frame_err output is enabled by defining SPI_SLAVE_ERR_EN.
module spi_slave_param #(
    parameter int DATA_W      = 8,
    parameter int TX_WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              rd_pend
`ifdef SPI_SLAVE_ERR_EN
    ,
    output logic              frame_err
`endif
);
    localparam int RX_W   = DATA_W + 2;
    localparam int CNT_W  = $clog2(RX_W + 1);
    localparam int WAIT_W = $clog2(TX_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0]  RX_LAST   = CNT_W'(RX_W - 1);
    localparam logic [CNT_W-1:0]  TX_BITS   = CNT_W'(DATA_W);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TX_WAIT_MAX - 1);

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [RX_W-2:0]   rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [RX_W-1:0]   rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              miso_q, miso_d;
    logic              rd_pend_q, rd_pend_d;
`ifdef SPI_SLAVE_ERR_EN
    logic              err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        miso_d     = miso_q;
        rd_pend_d  = rd_pend_q;
`ifdef SPI_SLAVE_ERR_EN
        err_d      = 1'b0;
`endif
        // Deselect ends any frame; only a frame that never reached DONE is an error.
        if (state_q != IDLE && SS_n) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            wait_cnt_d = '0;
            miso_d     = 1'b0;
`ifdef SPI_SLAVE_ERR_EN
            err_d      = (state_q != DONE);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d  = '0;
                    wait_cnt_d = '0;
                    miso_d     = 1'b0;
                    if (!SS_n) state_d = CHK_CMD;
                end
                CHK_CMD: begin
                    rx_shift_d = {rx_shift_q[RX_W-3:0], MOSI};
                    bit_cnt_d  = CNT_W'(1);
                    if (!MOSI)          state_d = WRITE;
                    else if (rd_pend_q) state_d = READ_DATA;
                    else                state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (bit_cnt_q == RX_LAST) begin
                        rx_data_d  = {rx_shift_q, MOSI};
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        wait_cnt_d = '0;
                        if (state_q == READ_DATA) begin
                            state_d = WAIT_TX;
                        end else begin
                            state_d = DONE;
                            if (state_q == READ_ADD) rd_pend_d = 1'b1;
                        end
                    end else begin
                        rx_shift_d = {rx_shift_q[RX_W-3:0], MOSI};
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    end
                end
                WAIT_TX: begin
                    if (tx_valid) begin
                        miso_d     = tx_data[DATA_W-1];
                        tx_shift_d = tx_data << 1;
                        bit_cnt_d  = CNT_W'(1);
                        state_d    = SEND;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        wait_cnt_d = '0;
                        state_d    = DONE;
`ifdef SPI_SLAVE_ERR_EN
                        err_d      = 1'b1;
`endif
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                SEND: begin
                    if (bit_cnt_q == TX_BITS) begin
                        miso_d    = 1'b0;
                        rd_pend_d = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        miso_d     = tx_shift_q[DATA_W-1];
                        tx_shift_d = tx_shift_q << 1;
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
            rd_pend_q  <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            miso_q     <= miso_d;
            rd_pend_q  <= rd_pend_d;
`ifdef SPI_SLAVE_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rd_pend  = rd_pend_q;
`ifdef SPI_SLAVE_ERR_EN
    assign frame_err = err_q;
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// tb/tb_spi_slave_param.sv - self-checking bench for spi_slave_param (DATA_W 8 and 16)
module tb_spi_slave_param;
    localparam int DW  = 8;
    localparam int TWM = 15;
    localparam int RXW = DW + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, ss_n, mosi, tx_valid, miso, rx_valid, rd_pend;
    logic [DW-1:0]  tx_data;
    logic [RXW-1:0] rx_data;
    logic           ss2, mosi2, tx_valid2, miso2, rx_valid2, rd_pend2;
    logic [15:0]    tx_data2;
    logic [17:0]    rx_data2;
`ifdef SPI_SLAVE_ERR_EN
    logic           frame_err, frame_err2;
`endif

    spi_slave_param #(.DATA_W(DW), .TX_WAIT_MAX(TWM)) dut (
        .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_valid(tx_valid), .rd_pend(rd_pend)
`ifdef SPI_SLAVE_ERR_EN
        , .frame_err(frame_err)
`endif
    );

    spi_slave_param #(.DATA_W(16), .TX_WAIT_MAX(TWM)) dut16 (
        .clk(clk), .rst(rst), .SS_n(ss2), .MOSI(mosi2), .MISO(miso2),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .tx_data(tx_data2),
        .tx_valid(tx_valid2), .rd_pend(rd_pend2)
`ifdef SPI_SLAVE_ERR_EN
        , .frame_err(frame_err2)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [RXW-1:0] m_rx;
    logic           m_pend;

    typedef struct {
        logic [RXW-1:0] w;
        int             abort_at;
        int             d;
        logic [DW-1:0]  txd;
        logic [RXW-1:0] exp_rx;
        logic           exp_pend;
    } vec_t;
    vec_t vecs[13];

    task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic exp_rxv, input logic exp_miso,
                              input logic exp_ferr);
        ck({tag, " rx_valid"}, rx_valid, exp_rxv);
        ck({tag, " miso"}, miso, exp_miso);
        ck({tag, " rx_data"}, rx_data, m_rx);
        ck({tag, " rd_pend"}, rd_pend, m_pend);
`ifdef SPI_SLAVE_ERR_EN
        ck({tag, " frame_err"}, frame_err, exp_ferr);
`endif
    endtask

    // Frame-level model: event times are derived from the frame shape, then each edge is checked.
    task automatic run_frame(input logic [RXW-1:0] w, input int abort_at, input int d,
                             input logic [DW-1:0] txd, input int extra);
        logic pend0, rdd, exp_rxv, exp_miso, exp_ferr;
        int   lt, done_t, a_t;
        pend0  = m_pend;
        rdd    = w[RXW-1] & pend0;
        lt     = (rdd && d < TWM) ? RXW + 1 + d : -1;
        done_t = !rdd ? RXW : (lt >= 0 ? lt + DW : RXW + TWM);
        a_t    = done_t + 1 + extra;
        if (abort_at > 0 && abort_at < a_t) a_t = abort_at;
        ss_n = 1'b0; mosi = 1'($urandom); tx_valid = 1'($urandom); tx_data = DW'($urandom);
        tick();
        check_outs("start", 1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= a_t; t++) begin
            ss_n = (t == a_t);
            mosi = (t <= RXW) ? w[RXW-t] : 1'($urandom);
            if (rdd && t > RXW && t <= (lt >= 0 ? lt : RXW + TWM)) tx_valid = (t == lt);
            else tx_valid = 1'($urandom);
            tx_data = (t == lt) ? txd : DW'($urandom);
            tick();
            exp_rxv = (t == RXW) && (t < a_t);
            if (exp_rxv) begin
                m_rx = w;
                if (w[RXW-1] && !pend0) m_pend = 1'b1;
            end
            if (lt >= 0 && t == lt + DW && t < a_t) m_pend = 1'b0;
            exp_miso = (lt >= 0 && t >= lt && t < lt + DW && t < a_t) ? txd[DW-1-(t-lt)] : 1'b0;
            exp_ferr = (t == a_t && a_t <= done_t) || (rdd && lt < 0 && t == RXW + TWM && t < a_t);
            check_outs("frame", exp_rxv, exp_miso, exp_ferr);
        end
        ss_n = 1'b1;
        tx_valid = 1'b0;
    endtask

    task automatic run16(input logic [17:0] w, input int d, input logic [15:0] txd);
        ss2 = 1'b0;
        tick();
        for (int t = 1; t <= 18; t++) begin
            mosi2 = w[18-t];
            tx_valid2 = (t == 9);
            tx_data2 = 16'hFFFF;
            tick();
            ck("w16 rx_valid", rx_valid2, (t == 18));
            ck("w16 miso idle", miso2, 1'b0);
        end
        tx_valid2 = 1'b0;
        ck("w16 rx_data", rx_data2, w);
        if (d >= 0) begin
            for (int c = 0; c < d; c++) begin
                tick();
                ck("w16 miso wait", miso2, 1'b0);
            end
            tx_valid2 = 1'b1; tx_data2 = txd;
            tick();
            tx_valid2 = 1'b0; tx_data2 = 16'h0000;
            ck("w16 miso msb", miso2, txd[15]);
            for (int b = 14; b >= 0; b--) begin
                tick();
                ck("w16 miso bit", miso2, txd[b]);
            end
            tick();
            ck("w16 miso end", miso2, 1'b0);
            ck("w16 rd_pend clear", rd_pend2, 1'b0);
        end
        ss2 = 1'b1;
        tick();
        ck("w16 rx_valid end", rx_valid2, 1'b0);
    endtask

    initial begin
        logic [RXW-1:0] w;
        logic [3:0]     hdr;
        rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
        ss2 = 1'b1; mosi2 = 1'b0; tx_valid2 = 1'b0; tx_data2 = '0;
        m_rx = '0; m_pend = 1'b0;
        tick(); tick();
        check_outs("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        vecs[0]  = '{10'h0A5, 0,  0,  8'h00, 10'h0A5, 1'b0};
        vecs[1]  = '{10'h203, 0,  0,  8'h00, 10'h203, 1'b1};
        vecs[2]  = '{10'h3FF, 0,  3,  8'hC3, 10'h3FF, 1'b0};
        vecs[3]  = '{10'h210, 0,  0,  8'h00, 10'h210, 1'b1};
        vecs[4]  = '{10'h355, 0,  99, 8'hFF, 10'h355, 1'b1};
        vecs[5]  = '{10'h2AA, 0,  14, 8'h5A, 10'h2AA, 1'b0};
        vecs[6]  = '{10'h0FF, 6,  0,  8'h00, 10'h2AA, 1'b0};
        vecs[7]  = '{10'h1F0, 0,  0,  8'h00, 10'h1F0, 1'b0};
        vecs[8]  = '{10'h3C0, 0,  0,  8'h00, 10'h3C0, 1'b1};
        vecs[9]  = '{10'h301, 16, 2,  8'h96, 10'h301, 1'b1};
        vecs[10] = '{10'h155, 10, 0,  8'h00, 10'h301, 1'b1};
        vecs[11] = '{10'h3AB, 13, 5,  8'hF0, 10'h3AB, 1'b1};
        vecs[12] = '{10'h200, 0,  0,  8'hFF, 10'h200, 1'b0};
        for (int i = 0; i < 13; i++) begin
            run_frame(vecs[i].w, vecs[i].abort_at, vecs[i].d, vecs[i].txd, 2);
            tick();
            ck($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_rx);
            ck($sformatf("vec%0d rd_pend", i), rd_pend, vecs[i].exp_pend);
        end

        // Reset in the middle of SEND, after three bits have left on MISO.
        run_frame(10'h203, 0, 0, 8'h00, 1);
        tick();
        ss_n = 1'b0;
        tick();
        hdr = 4'b1100;
        for (int i = 0; i < RXW; i++) begin
            mosi = (i < 4) ? hdr[3-i] : 1'b0;
            tick();
        end
        tx_valid = 1'b1; tx_data = 8'hC3;
        tick();
        tx_valid = 1'b0; tx_data = '0;
        ck("rst seq miso b7", miso, 1'b1);
        tick();
        ck("rst seq miso b6", miso, 1'b1);
        tick();
        ck("rst seq miso b5", miso, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0; ss_n = 1'b1;
        ck("rst miso", miso, 1'b0);
        ck("rst rd_pend", rd_pend, 1'b0);
        ck("rst rx_data", rx_data, 10'h000);
        ck("rst rx_valid", rx_valid, 1'b0);
        m_rx = '0; m_pend = 1'b0;
        tick();
        run_frame(10'h2F0, 0, 0, 8'h00, 1);
        ck("post-rst read_add", rd_pend, 1'b1);
        tick();

        for (int n = 0; n < 60; n++) begin
            w = RXW'($urandom);
            run_frame(w, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, RXW + TWM + DW)) : 0,
                      int'($urandom_range(0, TWM + 2)), DW'($urandom), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        run16(18'h0BEEF, -1, 16'h0000);
        run16(18'h20001, -1, 16'h0000);
        ck("w16 rd_pend set", rd_pend2, 1'b1);
        run16(18'h30000, 2, 16'hA55A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
